// File: rtl/anubis_key_schedule_ctrl.sv
// Anubis key-schedule sequencer: latches the cipher key, steps key_evolution round by round,
// streams round keys 0..NUM_ROUNDS over valid/ready. Optional round-key cache: KS_KEY_CACHE_EN.
module anubis_key_schedule_ctrl #(
  parameter int NUM_ROUNDS = 12,
  parameter int EVO_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_index,
  output logic [127:0] rk_data,
  output logic [3:0]   rc_index,
  input  logic [127:0] rc_value,
  output logic         ke_load_key,
  output logic [3:0]   ke_counter,
  output logic [3:0]   ke_round_num,
  output logic [127:0] ke_key,
  output logic [127:0] ke_round_constant,
  input  logic [127:0] ke_evolutioned_key
`ifdef KS_KEY_CACHE_EN
  ,
  input  logic [3:0]   cache_rd_addr,
  output logic [127:0] cache_rd_data,
  output logic         cache_full
`endif
);

  // state     | meaning
  // S_IDLE    | waiting for start
  // S_EMIT    | round key offered to consumer
  // S_LOAD    | load_key pulse into key_evolution
  // S_EVOLVE  | counter steps 1..EVO_CYCLES
  // S_CAPTURE | evolved key becomes next round key
  // S_DONE    | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_EMIT, S_LOAD, S_EVOLVE, S_CAPTURE, S_DONE
  } state_t;

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);
  localparam logic [3:0] EVO_LAST = 4'(EVO_CYCLES);

  state_t       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] key_q, key_d;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          key_d   = key_in;
          round_d = 4'd0;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (rk_ready) begin
          cnt_d   = 4'd0;
          state_d = (round_q == LAST_RND) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = 4'd1;
        state_d = S_EVOLVE;
      end
      S_EVOLVE: begin
        if (cnt_q == EVO_LAST) state_d = S_CAPTURE;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      S_CAPTURE: begin
        key_d   = ke_evolutioned_key;
        round_d = round_q + 4'd1;
        state_d = S_EMIT;
      end
      S_DONE: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      round_q <= 4'd0;
      cnt_q   <= 4'd0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
    end
  end

  // Outputs decode directly from state flops; anything not owned by a state is forced to 0.
  logic in_evo;
  assign in_evo = (state_q == S_LOAD) || (state_q == S_EVOLVE);

  always_comb begin
    busy              = (state_q == S_EMIT) || in_evo || (state_q == S_CAPTURE);
    done              = (state_q == S_DONE);
    rk_valid          = (state_q == S_EMIT);
    rk_index          = rk_valid ? round_q : 4'd0;
    rk_data           = rk_valid ? key_q : '0;
    ke_load_key       = (state_q == S_LOAD);
    ke_counter        = (in_evo || state_q == S_CAPTURE) ? cnt_q : 4'd0;
    ke_key            = in_evo ? key_q : '0;
    ke_round_num      = in_evo ? round_q + 4'd1 : 4'd0;
    rc_index          = in_evo ? round_q + 4'd1 : 4'd0;
    ke_round_constant = in_evo ? rc_value : '0;
  end

`ifdef KS_KEY_CACHE_EN
  logic [127:0] cache_mem [16];
  logic [127:0] cache_rd_data_q;
  logic         cache_full_q, cache_full_d;

  always_comb begin
    cache_full_d = cache_full_q;
    if (state_q == S_IDLE && start) cache_full_d = 1'b0;
    else if (state_d == S_DONE)     cache_full_d = 1'b1;
  end

  // Array contents survive reset; only the full flag is cleared.
  always_ff @(posedge clk) begin
    if (rk_valid && rk_ready) cache_mem[rk_index] <= rk_data;
    cache_rd_data_q <= cache_mem[cache_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!reset) cache_full_q <= 1'b0;
    else        cache_full_q <= cache_full_d;
  end

  assign cache_rd_data = cache_rd_data_q;
  assign cache_full    = cache_full_q;
`endif

endmodule

// File: tb/tb_anubis_key_schedule_ctrl.sv
// Directed bench for anubis_key_schedule_ctrl with a stand-in key_evolution whose output
// is only meaningful EVO_CYCLES after load_key. Cache checks compile in with KS_KEY_CACHE_EN.
module tb_anubis_key_schedule_ctrl;
  localparam int NR  = 12;
  localparam int EVO = 4;
  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B = 128'hfedcba98765432100123456789abcdef;

  logic         clk = 1'b0;
  logic         reset, start, rk_ready;
  logic [127:0] key_in;
  logic         busy, done, rk_valid, ke_load_key;
  logic [3:0]   rk_index, rc_index, ke_counter, ke_round_num;
  logic [127:0] rk_data, rc_value, ke_key, ke_round_constant, ke_evolutioned_key;
`ifdef KS_KEY_CACHE_EN
  logic [3:0]   cache_rd_addr;
  logic [127:0] cache_rd_data;
  logic         cache_full;
`endif

  int n_chk = 0;
  int n_err = 0;

  anubis_key_schedule_ctrl #(.NUM_ROUNDS(NR), .EVO_CYCLES(EVO)) dut (
    .clk(clk), .reset(reset), .start(start), .key_in(key_in),
    .busy(busy), .done(done), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_index(rk_index), .rk_data(rk_data), .rc_index(rc_index), .rc_value(rc_value),
    .ke_load_key(ke_load_key), .ke_counter(ke_counter), .ke_round_num(ke_round_num),
    .ke_key(ke_key), .ke_round_constant(ke_round_constant),
    .ke_evolutioned_key(ke_evolutioned_key)
`ifdef KS_KEY_CACHE_EN
    , .cache_rd_addr(cache_rd_addr), .cache_rd_data(cache_rd_data), .cache_full(cache_full)
`endif
  );

  always #5 clk = ~clk;

  assign rc_value = {32{rc_index}};

  // Stand-in key_evolution: rotate-left-by-1 xor round constant, garbage until EVO cycles elapse.
  logic [127:0] se_key = '0, se_rc = '0;
  logic [3:0]   se_cnt = 4'hf;
  always @(posedge clk) begin
    if (ke_load_key) begin
      se_key <= ke_key;
      se_rc  <= ke_round_constant;
      se_cnt <= 4'd0;
    end else if (se_cnt != 4'hf) begin
      se_cnt <= se_cnt + 4'd1;
    end
  end
  assign ke_evolutioned_key = (se_cnt >= 4'(EVO)) ? ({se_key[126:0], se_key[127]} ^ se_rc) : '1;

  function automatic logic [127:0] exp_key(input logic [127:0] k0, input int n);
    logic [127:0] r;
    logic [3:0]   t;
    r = k0;
    for (int i = 1; i <= n; i++) begin
      t = 4'(i);
      r = {r[126:0], r[127]} ^ {32{t}};
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int           hs_cyc[16];
  logic [3:0]   hs_idx[16];
  logic [127:0] hs_dat[16];
  int           ld_cyc[16];
  logic [3:0]   ld_rn[16];
  logic [3:0]   ctr_tr[6];
  int           n_hs, n_ld, done_cyc;
  bit           stall_bad;

  // Runs one schedule from IDLE; returns at the negedge of the done cycle (or after abort).
  task automatic run(input logic [127:0] key, input bit hold, input int sidx, input int slen,
                     input int abort_at);
    int c, left;
    logic [127:0] sdat;
    n_hs = 0; n_ld = 0; done_cyc = -1; stall_bad = 0; left = slen; sdat = '0;
    @(negedge clk);
    key_in = key; start = 1'b1; rk_ready = 1'b1;
    @(posedge clk);
    c = 1;
    while (c < 300) begin
      @(negedge clk);
      if (c == 1 && !hold) start = 1'b0;
      if (c == 10) key_in = ~key;
      if (c == 30) start = 1'b1;
      if (c == 31 && !hold) start = 1'b0;
      if (c == abort_at) begin
        chk("abort_pre_busy", busy, 1);
        chk("abort_pre_rn", ke_round_num, 7);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_valid", rk_valid, 0);
        chk("abort_ke", {ke_load_key, ke_counter, ke_round_num, rc_index}, 0);
        chk("abort_ke_key", ke_key, 0);
        chk("abort_ke_rc", ke_round_constant, 0);
        reset = 1'b1; start = 1'b0;
        return;
      end
      if (rk_valid && rk_index == 4'(sidx) && left > 0) begin
        rk_ready = 1'b0;
        if (left == slen) sdat = rk_data;
        else if (rk_data !== sdat) stall_bad = 1;
        if (ke_load_key) stall_bad = 1;
        left--;
      end else begin
        rk_ready = 1'b1;
      end
      if (rk_valid && rk_ready && n_hs < 16) begin
        hs_cyc[n_hs] = c; hs_idx[n_hs] = rk_index; hs_dat[n_hs] = rk_data; n_hs++;
      end
      if (ke_load_key && n_ld < 16) begin
        ld_cyc[n_ld] = c; ld_rn[n_ld] = ke_round_num; n_ld++;
      end
      if (c >= 2 && c <= 7) ctr_tr[c-2] = ke_counter;
      if (done) begin
        done_cyc = c;
        return;
      end
      @(posedge clk);
      c++;
    end
    chk("run_timeout", 1, 0);
  endtask

  task automatic check_run(input string nm, input logic [127:0] key, input int sidx, input int slen);
    chk({nm, "_n_hs"}, n_hs, NR + 1);
    for (int k = 0; k < n_hs && k <= NR; k++) begin
      chk($sformatf("%s_idx%0d", nm, k), hs_idx[k], k);
      chk($sformatf("%s_dat%0d", nm, k), hs_dat[k], exp_key(key, k));
      chk($sformatf("%s_hscyc%0d", nm, k), hs_cyc[k], 1 + (EVO + 3) * k + ((k >= sidx) ? slen : 0));
    end
    chk({nm, "_n_ld"}, n_ld, NR);
    for (int r = 1; r <= n_ld && r <= NR; r++) begin
      chk($sformatf("%s_ldrn%0d", nm, r), ld_rn[r-1], r);
      chk($sformatf("%s_ldcyc%0d", nm, r), ld_cyc[r-1], 2 + (EVO + 3) * (r - 1) + ((r > sidx) ? slen : 0));
    end
    chk({nm, "_done_cyc"}, done_cyc, 2 + (EVO + 3) * NR + slen);
    chk({nm, "_ctr"}, {ctr_tr[0], ctr_tr[1], ctr_tr[2], ctr_tr[3], ctr_tr[4], ctr_tr[5]},
        {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4});
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; rk_ready = 1'b1; key_in = '0;
`ifdef KS_KEY_CACHE_EN
    cache_rd_addr = 4'd0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {busy, done, rk_valid, ke_load_key}, 0);
    chk("rst_idx", {rk_index, rc_index, ke_counter, ke_round_num}, 0);
    chk("rst_data", rk_data, 0);
    reset = 1'b1;

    run('0, 0, 15, 0, 0);
    check_run("zero", '0, 15, 0);

    run(KEY_A, 0, 15, 0, 0);
    check_run("keya", KEY_A, 15, 0);
`ifdef KS_KEY_CACHE_EN
    chk("cache_full_done", cache_full, 1);
    for (int a = 0; a <= NR; a++) begin
      @(negedge clk);
      cache_rd_addr = 4'(a);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("cache_rd%0d", a), cache_rd_data, exp_key(KEY_A, a));
    end
    chk("cache_full_idle", cache_full, 1);
`endif

    run(KEY_A, 0, 3, 5, 0);
    check_run("stall", KEY_A, 3, 5);
    chk("stall_stable", stall_bad, 0);

    run(KEY_B, 0, 15, 0, 1 + (EVO + 3) * 6 + 3);
`ifdef KS_KEY_CACHE_EN
    chk("cache_full_rst", cache_full, 0);
`endif
    run(KEY_B, 0, 15, 0, 0);
    check_run("restart", KEY_B, 15, 0);

    run(KEY_B, 1, 15, 0, 0);
    check_run("hold", KEY_B, 15, 0);
    @(posedge clk);
    @(negedge clk);
    chk("hold_idle", {busy, done, rk_valid}, 0);
    @(posedge clk);
    @(negedge clk);
    chk("hold_reemit", {busy, rk_valid, rk_index}, {1'b1, 1'b1, 4'd0});
    chk("hold_reemit_dat", rk_data, ~KEY_B);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
